// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle FSM sequencing the 16-bit RISC datapath; `ILLEGAL_TRAP_EN traps undefined opcodes into HALT.
module multicycle_ctrl #(
  parameter bit START_IN_RUN = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        test,
  input  logic [15:0] opcode,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        Imm_5or8,
  output logic        RegWrite,
  output logic        OutREn,
  output logic        Branch,
  output logic        PSWEn,
  output logic        PCWrite,
  output logic        IorD,
  output logic        RegDst,
  output logic        LLorLH,
  output logic        ALUSrcA,
  output logic        JAorJR,
  output logic [1:0]  ALUop,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  MemtoReg,
  output logic [1:0]  PCSrc,
  output logic        halted,
  output logic        illegal,
  output logic [3:0]  state
);
  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADDR, MEM_RD,
    MEM_WB, MEM_WR, LOADIMM, BRANCH, JUMP, OUTR, HALT
  } state_t;
  state_t r_state, w_next;
  logic r_illegal;
  logic [4:0] w_op, w_opm1;
  logic w_go, w_trap, w_on, w_jal, w_jr;
  assign w_op = opcode[15:11];
  assign w_opm1 = w_op - 5'd1;
  assign w_go = run && !test;
  assign w_jal = w_op == 5'd12;
  assign w_jr = w_op == 5'd13;
`ifdef ILLEGAL_TRAP_EN
  assign w_trap = r_state == DECODE && opcode[15];
`else
  assign w_trap = 1'b0;
`endif
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:     w_next = w_go ? FETCH : IDLE;
      FETCH:    w_next = DECODE;
      DECODE:
        case (w_op)
          5'd0:                   w_next = FETCH;
          5'd1, 5'd2, 5'd3, 5'd4: w_next = EXEC_R;
          5'd5:                   w_next = EXEC_I;
          5'd6, 5'd7:             w_next = MEM_ADDR;
          5'd8, 5'd9:             w_next = LOADIMM;
          5'd10:                  w_next = BRANCH;
          5'd11, 5'd12, 5'd13:    w_next = JUMP;
          5'd14:                  w_next = OUTR;
          5'd15:                  w_next = HALT;
          default:                w_next = w_trap ? HALT : FETCH;
        endcase
      EXEC_R, EXEC_I: w_next = ALU_WB;
      MEM_ADDR: w_next = w_op == 5'd7 ? MEM_WR : MEM_RD;
      MEM_RD:   w_next = MEM_WB;
      HALT:     w_next = HALT;
      ALU_WB, MEM_WB, MEM_WR, LOADIMM, BRANCH, JUMP, OUTR: w_next = w_go ? FETCH : IDLE;
      default:  w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= START_IN_RUN ? FETCH : IDLE;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_illegal <= r_illegal | w_trap;
    end
  end
  // Every decoded output is masked while rst is high so the reset cycle drives nothing.
  assign w_on     = !rst;
  assign IRWrite  = w_on && r_state == FETCH;
  assign PCWrite  = w_on && (r_state == FETCH || r_state == JUMP);
  assign Imm_5or8 = w_on && r_state == DECODE;
  assign ALUSrcA  = w_on && (r_state == EXEC_R || r_state == EXEC_I || r_state == MEM_ADDR);
  assign ALUSrcB  = !w_on ? 2'b00 : r_state == FETCH ? 2'b01 :
                    (r_state == DECODE || r_state == EXEC_I || r_state == MEM_ADDR) ? 2'b10 : 2'b00;
  assign ALUop    = (w_on && r_state == EXEC_R) ? w_opm1[1:0] : 2'b00;
  assign PSWEn    = w_on && (r_state == EXEC_R || r_state == EXEC_I);
  assign RegWrite = w_on && (r_state == ALU_WB || r_state == MEM_WB || r_state == LOADIMM ||
                    (r_state == JUMP && w_jal));
  assign MemtoReg = !w_on ? 2'b00 : r_state == MEM_WB ? 2'b01 : r_state == LOADIMM ? 2'b10 :
                    (r_state == JUMP && w_jal) ? 2'b11 : 2'b00;
  assign IorD     = w_on && (r_state == MEM_RD || r_state == MEM_WR);
  assign MemWrite = w_on && r_state == MEM_WR;
  assign LLorLH   = w_on && r_state == LOADIMM && w_op == 5'd9;
  assign Branch   = w_on && r_state == BRANCH;
  assign PCSrc    = !w_on ? 2'b00 : r_state == BRANCH ? 2'b01 :
                    r_state == JUMP ? (w_jr ? 2'b11 : 2'b10) : 2'b00;
  assign JAorJR   = 1'b0;
  assign OutREn   = w_on && r_state == OUTR;
  assign halted   = w_on && r_state == HALT;
  // SW, LH and BCC carry Rd in the RB field, so route it there once the instruction is loaded.
  assign RegDst   = w_on && r_state != IDLE && r_state != FETCH &&
                    (w_op == 5'd7 || w_op == 5'd9 || w_op == 5'd10);
  assign illegal  = r_illegal;
  assign state    = r_state;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed-vector bench for multicycle_ctrl.
module tb_multicycle_ctrl;
  logic clk = 1'b0, rst = 1'b1, run = 1'b0, test = 1'b0;
  logic [15:0] opcode = 16'h0800;
  logic MemWrite, IRWrite, Imm_5or8, RegWrite, OutREn, Branch, PSWEn, PCWrite;
  logic IorD, RegDst, LLorLH, ALUSrcA, JAorJR, halted, illegal;
  logic [1:0] ALUop, ALUSrcB, MemtoReg, PCSrc;
  logic [3:0] state;
  logic [21:0] all_out;
  int n_chk = 0, n_fail = 0;
  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .run(run), .test(test), .opcode(opcode),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .Imm_5or8(Imm_5or8), .RegWrite(RegWrite),
    .OutREn(OutREn), .Branch(Branch), .PSWEn(PSWEn), .PCWrite(PCWrite), .IorD(IorD),
    .RegDst(RegDst), .LLorLH(LLorLH), .ALUSrcA(ALUSrcA), .JAorJR(JAorJR), .ALUop(ALUop),
    .ALUSrcB(ALUSrcB), .MemtoReg(MemtoReg), .PCSrc(PCSrc), .halted(halted),
    .illegal(illegal), .state(state)
  );
  assign all_out = {MemWrite, IRWrite, Imm_5or8, RegWrite, OutREn, Branch, PSWEn, PCWrite,
                    IorD, RegDst, LLorLH, ALUSrcA, JAorJR, ALUop, ALUSrcB, MemtoReg, PCSrc, halted};
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
  endtask
  initial begin
    cyc();
    chk("rst_state", state, 0);
    chk("rst_outs", all_out, 0);
    chk("rst_illegal", illegal, 0);
    rst = 1'b0; run = 1'b1;
    cyc(); chk("add_s1", state, 1); chk("add_pcw_f", PCWrite, 1); chk("add_irw", IRWrite, 1); chk("add_srcb_f", ALUSrcB, 1);
    cyc(); chk("add_s2", state, 2); chk("add_pcw_d", PCWrite, 0); chk("add_srcb_d", ALUSrcB, 2); chk("add_imm_d", Imm_5or8, 1);
    cyc(); chk("add_s3", state, 3); chk("add_psw", PSWEn, 1); chk("add_aluop", ALUop, 0); chk("add_srca", ALUSrcA, 1);
    chk("add_rw3", RegWrite, 0); chk("add_pcw3", PCWrite, 0);
    cyc(); chk("add_s5", state, 5); chk("add_rw5", RegWrite, 1); chk("add_m2r5", MemtoReg, 0); chk("add_pcw5", PCWrite, 0);
    cyc(); chk("add_s1b", state, 1);
    opcode = 16'h1800;
    cyc(); chk("sub_s2", state, 2);
    cyc(); chk("sub_s3", state, 3); chk("sub_aluop", ALUop, 2);
    cyc(); chk("sub_s5", state, 5);
    cyc(); chk("sub_s1", state, 1);
    opcode = 16'h3000;
    cyc(); chk("lw_s2", state, 2); chk("lw_rdst", RegDst, 0);
    cyc(); chk("lw_s6", state, 6); chk("lw_srca", ALUSrcA, 1); chk("lw_srcb", ALUSrcB, 2); chk("lw_imm6", Imm_5or8, 0);
    cyc(); chk("lw_s7", state, 7); chk("lw_iord", IorD, 1); chk("lw_mw7", MemWrite, 0);
    run = 1'b0;
    cyc(); chk("lw_s8", state, 8); chk("lw_rw8", RegWrite, 1); chk("lw_m2r8", MemtoReg, 1); chk("lw_mw8", MemWrite, 0);
    cyc(); chk("lw_idle", state, 0);
    run = 1'b1; test = 1'b1;
    cyc(); chk("test_s0a", state, 0); chk("test_outs_a", all_out, 0);
    cyc(); chk("test_s0b", state, 0); chk("test_outs_b", all_out, 0);
    test = 1'b0;
    cyc(); chk("resume_s1", state, 1);
    opcode = 16'h3800;
    cyc(); chk("sw_s2", state, 2); chk("sw_rdst2", RegDst, 1);
    cyc(); chk("sw_s6", state, 6); chk("sw_rdst6", RegDst, 1); chk("sw_mw6", MemWrite, 0);
    cyc(); chk("sw_s9", state, 9); chk("sw_rdst9", RegDst, 1); chk("sw_mw9", MemWrite, 1); chk("sw_iord9", IorD, 1);
    cyc(); chk("sw_s1", state, 1); chk("sw_mw1", MemWrite, 0);
    opcode = 16'h6000;
    cyc(); chk("jal_s2", state, 2);
    cyc(); chk("jal_s12", state, 12); chk("jal_pcw", PCWrite, 1); chk("jal_pcsrc", PCSrc, 2);
    chk("jal_rw", RegWrite, 1); chk("jal_m2r", MemtoReg, 3);
    cyc(); chk("jal_s1", state, 1);
    opcode = 16'h6800;
    cyc(); chk("jr_s2", state, 2);
    cyc(); chk("jr_s12", state, 12); chk("jr_pcsrc", PCSrc, 3); chk("jr_jaorjr", JAorJR, 0);
    chk("jr_rw", RegWrite, 0); chk("jr_pcw", PCWrite, 1);
    cyc(); chk("jr_s1", state, 1);
    opcode = 16'h4800;
    cyc(); chk("lh_s2", state, 2);
    cyc(); chk("lh_s10", state, 10); chk("lh_rw", RegWrite, 1); chk("lh_m2r", MemtoReg, 2);
    chk("lh_llorlh", LLorLH, 1); chk("lh_rdst", RegDst, 1);
    cyc(); chk("lh_s1", state, 1);
    opcode = 16'h5000;
    cyc(); chk("bcc_s2", state, 2);
    cyc(); chk("bcc_s11", state, 11); chk("bcc_branch", Branch, 1); chk("bcc_pcsrc", PCSrc, 1); chk("bcc_pcw", PCWrite, 0);
    cyc(); chk("bcc_s1", state, 1);
    opcode = 16'h7000;
    cyc(); chk("out_s2", state, 2);
    cyc(); chk("out_s13", state, 13); chk("out_en", OutREn, 1);
    cyc(); chk("out_s1", state, 1);
    opcode = 16'h2800;
    cyc(); chk("addi_s2", state, 2);
    cyc(); chk("addi_s4", state, 4); chk("addi_srcb", ALUSrcB, 2); chk("addi_imm", Imm_5or8, 0); chk("addi_psw", PSWEn, 1);
    cyc(); chk("addi_s5", state, 5);
    cyc(); chk("addi_s1", state, 1);
    opcode = 16'h0000;
    cyc(); chk("nop_s2", state, 2);
    cyc(); chk("nop_s1", state, 1);
    opcode = 16'hF800;
    cyc(); chk("ill_s2", state, 2);
    cyc();
`ifdef ILLEGAL_TRAP_EN
    chk("ill_state", state, 14); chk("ill_halted", halted, 1); chk("ill_flag", illegal, 1);
    cyc(); chk("ill_stays", state, 14);
`else
    chk("ill_state", state, 1); chk("ill_halted", halted, 0); chk("ill_flag", illegal, 0);
`endif
    rst = 1'b1;
    #1 chk("rstcyc_outs", all_out, 0);
    cyc(); chk("rst2_state", state, 0); chk("rst2_illegal", illegal, 0);
    rst = 1'b0; opcode = 16'h7800;
    cyc(); chk("halt_s1", state, 1);
    cyc(); chk("halt_s2", state, 2); chk("halt_h2", halted, 0);
    cyc(); chk("halt_s14", state, 14); chk("halt_h", halted, 1); chk("halt_outs", all_out, 22'h1);
    run = 1'b0;
    cyc(); chk("halt_hold", state, 14); chk("halt_h_hold", halted, 1);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
